// File: rtl/divider_pkg.sv
// Shared definitions for the RV32M divide unit: opcode and state encodings,
// plus the typed state enum used by the controller.
`ifndef DIVIDER_DEFINES_SVH
`define DIVIDER_DEFINES_SVH

`define DIV_OP_DIV   2'b00
`define DIV_OP_DIVU  2'b01
`define DIV_OP_REM   2'b10
`define DIV_OP_REMU  2'b11

`define DIV_IDLE     2'd0
`define DIV_BUSY     2'd1
`define DIV_DONE     2'd2

`endif

package divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE = `DIV_IDLE,
    S_BUSY = `DIV_BUSY,
    S_DONE = `DIV_DONE
  } div_state_e;

  // Last value loaded into the iteration counter (32 quotient bits).
  localparam logic [4:0] DIV_LAST_BIT = 5'd31;

endpackage

// File: rtl/divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Optional feature macro: DIV_EARLY_OUT_EN -- when defined, operands with
// |a| < |b| skip the iteration and finish in one cycle.
module divider
  import divider_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            valid_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            ready_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};

  div_state_e      state_q, state_d;
  logic [4:0]      count_q, count_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvd_q, dvd_d;       // dividend shifts out, quotient shifts in
  logic [XLEN-1:0] dvs_q, dvs_d;       // divisor magnitude
  logic [XLEN-1:0] result_q, result_d;
  logic            is_rem_q, is_rem_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;

  // Request decode and operand conditioning.
  logic            accept;
  logic            in_signed, in_rem;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            b_zero, ovf, early, take_short;
  logic [XLEN-1:0] short_res;

  assign ready_o   = (state_q == S_IDLE);
  assign valid_o   = (state_q == S_DONE) && !flush_i;
  assign result_o  = result_q;

  assign accept    = valid_i && ready_o && !flush_i;
  assign in_signed = ~op_i[0];
  assign in_rem    = op_i[1];
  assign a_mag     = (in_signed && a_i[XLEN-1]) ? (ZERO - a_i) : a_i;
  assign b_mag     = (in_signed && b_i[XLEN-1]) ? (ZERO - b_i) : b_i;
  assign b_zero    = (b_i == ZERO);
  assign ovf       = in_signed && (a_i == MIN_NEG) && (b_i == ALL_ONE);
`ifdef DIV_EARLY_OUT_EN
  assign early     = !b_zero && (a_mag < b_mag);
`else
  assign early     = 1'b0;
`endif
  assign take_short = b_zero || ovf || early;

  // Divide-by-zero, signed overflow and early-out results; in all three the
  // remainder is either the raw dividend or zero.
  assign short_res = b_zero ? (in_rem ? a_i : ALL_ONE) :
                     ovf    ? (in_rem ? ZERO : MIN_NEG) :
                              (in_rem ? a_i : ZERO);

  // One restoring step: trial-subtract the divisor from the shifted remainder.
  logic [XLEN:0]   trial;
  logic            fits;
  logic [XLEN-1:0] rem_step, quo_step, rem_fix, quo_fix, final_res;

  assign trial     = {rem_q, dvd_q[XLEN-1]} - {1'b0, dvs_q};
  assign fits      = ~trial[XLEN];
  assign rem_step  = fits ? trial[XLEN-1:0] : {rem_q[XLEN-2:0], dvd_q[XLEN-1]};
  assign quo_step  = {dvd_q[XLEN-2:0], fits};
  assign quo_fix   = neg_quo_q ? (ZERO - quo_step) : quo_step;
  assign rem_fix   = neg_rem_q ? (ZERO - rem_step) : rem_step;
  assign final_res = is_rem_q ? rem_fix : quo_fix;

  // Next-state, iteration datapath and result capture.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_rem_d  = in_rem;
          neg_quo_d = in_signed && (a_i[XLEN-1] ^ b_i[XLEN-1]);
          neg_rem_d = in_signed && a_i[XLEN-1];
          if (take_short) begin
            result_d = short_res;
            state_d  = S_DONE;
          end else begin
            rem_d   = ZERO;
            dvd_d   = a_mag;
            dvs_d   = b_mag;
            count_d = DIV_LAST_BIT;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        rem_d = rem_step;
        dvd_d = quo_step;
        if (count_q == 5'd0) begin
          result_d = final_res;
          state_d  = S_DONE;
        end else begin
          count_d = count_q - 5'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flush abandons any in-flight op and leaves the last result untouched.
    if (flush_i) begin
      state_d  = S_IDLE;
      count_d  = 5'd0;
      result_d = result_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      count_q   <= 5'd0;
      rem_q     <= ZERO;
      dvd_q     <= ZERO;
      dvs_q     <= ZERO;
      result_q  <= ZERO;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for the divide unit: directed cases, flush, reset,
// back-to-back issue and randomized operands against an arithmetic model.
module tb_divider;

  logic        clk;
  logic        rst_i;
  logic        flush_i;
  logic        valid_i;
  logic [1:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] result_o;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  divider #(.XLEN(32)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .flush_i  (flush_i),
    .valid_i  (valid_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .ready_o  (ready_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result from RISC-V division semantics using native arithmetic.
  function automatic logic [31:0] model_res(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    bit sgn = (op == OP_DIV) || (op == OP_REM);
    bit rem = op[1];
    int sa = int'(a);
    int sb = int'(b);
    if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
      return rem ? 32'(sa % sb) : 32'(sa / sb);
    end
    return rem ? (a % b) : (a / b);
  endfunction

  // Reference latency in cycles from accept edge to the valid cycle.
  function automatic int model_lat(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    bit sgn = (op == OP_DIV) || (op == OP_REM);
    longint ma, mb;
    ma = sgn ? longint'(int'(a)) : longint'(a);
    mb = sgn ? longint'(int'(b)) : longint'(b);
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (b == 32'd0) return 1;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 1;
`endif
    return 33;
  endfunction

  // Issue one op and wait (bounded) for its result; lat=-1 on timeout.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic after_v);
    int k;
    k = 0;
    @(negedge clk);
    while (!ready_o && k < 100) begin
      @(negedge clk);
      k++;
    end
    op_i = op; a_i = a; b_i = b; valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    k = 0;
    while (!valid_o && k < 100) begin
      @(negedge clk);
      k++;
    end
    lat = valid_o ? k + 1 : -1;
    res = result_o;
    @(negedge clk);
    after_v = valid_o;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0;
    op_i = 2'b00; a_i = 32'd0; b_i = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (ready_o !== 1'b1) begin
      n_miss++; $display("FAIL reset_ready got=%b want=1", ready_o);
    end else $display("reset_ready ok");
    n_vec++;
    if (valid_o !== 1'b0) begin
      n_miss++; $display("FAIL reset_valid got=%b want=0", valid_o);
    end else $display("reset_valid ok");
    n_vec++;
    if (result_o !== 32'd0) begin
      n_miss++; $display("FAIL reset_result got=%h want=00000000", result_o);
    end else $display("reset_result ok");
    rst_i = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[10];
    int lat;
    logic [31:0] res;
    logic after_v;
    int early_lat;
`ifdef DIV_EARLY_OUT_EN
    early_lat = 1;
`else
    early_lat = 33;
`endif
    v[0] = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         33};
    v[1] = '{OP_REMU, 32'd100,        32'd7,          32'd2,          33};
    v[2] = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
    v[3] = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
    v[4] = '{OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    v[5] = '{OP_REM,  32'd5,          32'd0,          32'd5,          1};
    v[6] = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    v[7] = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    v[8] = '{OP_DIVU, 32'd3,          32'd10,         32'd0,          early_lat};
    v[9] = '{OP_REM,  32'hFFFF_FFFD,  32'd10,         32'hFFFF_FFFD,  early_lat};
    for (int i = 0; i < 10; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, lat, res, after_v);
      n_vec++;
      if (res !== v[i].res || lat != v[i].lat || after_v !== 1'b0) begin
        n_miss++;
        $display("FAIL directed[%0d] op=%0d a=%h b=%h got res=%h lat=%0d trail_valid=%b want res=%h lat=%0d trail_valid=0",
                 i, v[i].op, v[i].a, v[i].b, res, lat, after_v, v[i].res, v[i].lat);
      end else begin
        $display("directed[%0d] op=%0d a=%h b=%h res=%h lat=%0d ok", i, v[i].op, v[i].a, v[i].b, res, lat);
      end
    end
  endtask

  task automatic test_flush();
    int seen, k, lat;
    logic [31:0] res;
    logic after_v, busy_ready;
    // Flush mid-iteration.
    k = 0;
    @(negedge clk);
    while (!ready_o && k < 100) begin @(negedge clk); k++; end
    op_i = OP_DIVU; a_i = 32'd1000; b_i = 32'd3; valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    busy_ready = ready_o;
    repeat (9) @(negedge clk);
    valid_i = 1'b0;
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    n_vec++;
    if (busy_ready !== 1'b0 || ready_o !== 1'b1) begin
      n_miss++; $display("FAIL flush_ready got busy=%b after=%b want busy=0 after=1", busy_ready, ready_o);
    end else $display("flush_ready ok");
    seen = 0;
    repeat (40) begin @(negedge clk); if (valid_o) seen++; end
    n_vec++;
    if (seen != 0) begin
      n_miss++; $display("FAIL flush_no_result got=%0d pulses want=0", seen);
    end else $display("flush_no_result ok");
    run_op(OP_DIVU, 32'd9, 32'd3, lat, res, after_v);
    n_vec++;
    if (res !== 32'd3 || lat != 33) begin
      n_miss++; $display("FAIL flush_next_op got res=%h lat=%0d want res=00000003 lat=33", res, lat);
    end else $display("flush_next_op res=%h lat=%0d ok", res, lat);

    // Flush in DONE suppresses the pulse.
    @(negedge clk);
    op_i = OP_DIVU; a_i = 32'd5; b_i = 32'd0; valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    flush_i = 1'b1;
    #1;
    n_vec++;
    if (valid_o !== 1'b0) begin
      n_miss++; $display("FAIL flush_done_suppress got=%b want=0", valid_o);
    end else $display("flush_done_suppress ok");
    @(negedge clk);
    flush_i = 1'b0;

    // Request coinciding with flush is dropped.
    valid_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; flush_i = 1'b0;
    n_vec++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      n_miss++; $display("FAIL flush_same_cycle got ready=%b valid=%b want ready=1 valid=0", ready_o, valid_o);
    end else $display("flush_same_cycle ok");
  endtask

  task automatic test_reset_mid();
    int seen, k;
    k = 0;
    @(negedge clk);
    while (!ready_o && k < 100) begin @(negedge clk); k++; end
    op_i = OP_DIVU; a_i = 32'd1000; b_i = 32'd3; valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    repeat (5) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    n_vec++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 32'd0) begin
      n_miss++; $display("FAIL reset_mid got ready=%b valid=%b res=%h want ready=1 valid=0 res=00000000",
                         ready_o, valid_o, result_o);
    end else $display("reset_mid ok");
    seen = 0;
    repeat (40) begin @(negedge clk); if (valid_o) seen++; end
    n_vec++;
    if (seen != 0) begin
      n_miss++; $display("FAIL reset_mid_lost got=%0d pulses want=0", seen);
    end else $display("reset_mid_lost ok");
  endtask

  task automatic test_back_to_back();
    logic [31:0] ta[2];
    logic [31:0] tb[2];
    int n_acc, n_res, n_bad;
    logic [31:0] exp;
    ta[0] = 32'd1000; tb[0] = 32'd7;
    ta[1] = 32'd77;   tb[1] = 32'd0;
    for (int c = 0; c < 2; c++) begin
      n_acc = 0; n_res = 0; n_bad = 0;
      exp = model_res(OP_DIVU, ta[c], tb[c]);
      @(negedge clk);
      op_i = OP_DIVU; a_i = ta[c]; b_i = tb[c]; valid_i = 1'b1;
      for (int i = 0; i < 120; i++) begin
        if (valid_o) begin
          n_res++;
          if (result_o !== exp) n_bad++;
        end
        if (ready_o && valid_i) n_acc++;
        @(negedge clk);
      end
      valid_i = 1'b0;
      repeat (40) begin
        if (valid_o) begin
          n_res++;
          if (result_o !== exp) n_bad++;
        end
        @(negedge clk);
      end
      n_vec++;
      if (n_acc != n_res || n_acc < 3 || n_bad != 0) begin
        n_miss++;
        $display("FAIL back_to_back[%0d] got accepts=%0d results=%0d wrong=%0d want equal counts, >=3, wrong=0",
                 c, n_acc, n_res, n_bad);
      end else $display("back_to_back[%0d] accepts=%0d results=%0d ok", c, n_acc, n_res);
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b, res, er;
    int lat, el;
    logic after_v;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: begin a = 32'($urandom_range(0, 200)); b = 32'($urandom_range(201, 100000)); end
        4: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: ;
      endcase
      er = model_res(op, a, b);
      el = model_lat(op, a, b);
      run_op(op, a, b, lat, res, after_v);
      n_vec++;
      if (res !== er || lat != el) begin
        n_miss++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h got res=%h lat=%0d want res=%h lat=%0d",
                 i, op, a, b, res, lat, er, el);
      end else begin
        $display("random[%0d] op=%0d a=%h b=%h res=%h lat=%0d ok", i, op, a, b, res, lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Multi-cycle RV32M divide unit; inverse companion to the single-cycle ALU. The ALU has no multiply/divide path.
- Executes DIV, DIVU, REM and REMU with a radix-2 restoring algorithm, producing one quotient bit per cycle.
- Sits beside the ALU in the execute stage. The pipeline stalls on ready_o/valid_o.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset
- flush_i  input  1  abort in-flight op (branch/exception flush)
- valid_i  input  1  request strobe
- op_i  input  2  `DIV_OP_DIV=00, `DIV_OP_DIVU=01, `DIV_OP_REM=10, `DIV_OP_REMU=11
- a_i  input  32  dividend (rs1)
- b_i  input  32  divisor (rs2)
- ready_o  output  1  unit idle, can accept
- valid_o  output  1  result valid, single-cycle pulse
- result_o  output  32  quotient or remainder

Interface (already decided):
- One clock, clk_i.
- Reset rst_i is synchronous and active-high.

Behaviour:
- Reset values: state=IDLE, ready_o=1, valid_o=0, result_o=0, counter=0, all datapath registers 0.
- Accept: a request is accepted on a rising edge where valid_i && ready_o. Operands and op are latched at that edge.
- valid_i while not ready_o is ignored. There is no queue.
- States:
  - IDLE: ready_o=1. On accept, go to DONE if a special case applies, otherwise to BUSY with count=31.
  - BUSY: ready_o=0. Each cycle:
    - rem = {rem[30:0], dvd[31]}, dvd <<= 1.
    - If rem >= divisor_mag: rem -= divisor_mag and shift in quotient bit 1; else shift in 0.
    - Decrement count. At count==0, go to DONE.
  - DONE: valid_o=1 and result_o is driven for exactly this cycle. Next state is IDLE.
  - valid_o has no output backpressure.
  - ready_o is 0 in DONE, so back-to-back issue can accept no earlier than the cycle after valid_o.
- Latency (normal): accept edge at T, 32 BUSY cycles, valid_o high in cycle T+33.
- Signed ops (DIV/REM):
  - Latch |a| and |b|.
  - Negate the quotient if a[31]^b[31].
  - The remainder takes the sign of the dividend.
  - The final negation is applied on the BUSY->DONE transition, with no extra cycle.
- Unsigned ops (DIVU/REMU): magnitudes equal the raw operands; no negation.
- Special cases (always present, 1-cycle path; valid_o at T+1):
  - b==0: quotient = 0xFFFFFFFF (all ops), remainder = a.
  - DIV/REM with a==0x80000000 and b==0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- result_o:
  - Holds its last value outside DONE.
  - It is only meaningful while valid_o=1.
- flush_i:
  - Highest priority after rst_i. In any state the next state is IDLE and valid_o=0 next cycle.
  - A result in DONE during a flush is suppressed: valid_o forced 0 that cycle.
  - valid_i in the same cycle as flush_i is not accepted.
- rst_i mid-operation: returns to reset values next edge; the in-flight op is lost.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN
- Defined:
  - In IDLE, if the unsigned magnitude |a| < |b| (and b!=0), go straight to DONE with quotient=0 and remainder=a (raw, sign preserved).
  - valid_o at T+1.
- Undefined: such operands take the full 32-cycle path with identical results.
- Results are bit-identical either way; only latency differs.

Decomposition:
- Shared defines go in the core define header:
  - `DIV_OP_DIV, `DIV_OP_DIVU, `DIV_OP_REM, `DIV_OP_REMU
  - state encodings `DIV_IDLE/`DIV_BUSY/`DIV_DONE
- No sub-module. The negate/abs helpers are local continuous assigns, and the iteration datapath is one always block.

Test Plan:
- DIVU a=100, b=7 -> valid_o at T+33, result_o=14. REMU same operands -> 2.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD (-3). REM same operands -> 0xFFFFFFFF (-1).
- DIVU a=5, b=0 -> valid_o at T+1, result 0xFFFFFFFF. REM a=5, b=0 -> 5.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 at T+1. REM same operands -> 0.
- DIVU 1000/3 accepted, flush_i pulsed at T+10 -> ready_o=1 at T+11, no valid_o ever for that op. New DIVU 9/3 then returns 3 at its own T+33.
- DIVU a=3, b=10: with DIV_EARLY_OUT_EN, result 0 at T+1; without it, result 0 at T+33. Also, holding valid_i high while busy -> exactly one result per accept.
